interrupt_sequencer: RTL and testbench

//  Sequences entry into and exit from interrupt service for the 5-stage pipeline.
//  - Freezes fetch and drains the in-flight instructions.
//  - Asks the memory stage to push the return PC, then the CCR.
//  - Redirects fetch to the interrupt vector and masks new interrupts until RTI retires in WB.

---
 rtl/intc_pkg.sv | 16 +
 rtl/intc_edge_sync.sv | 31 +++
 rtl/interrupt_sequencer.sv | 125 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt sequencer; the state encoding is also
// consumed by the fetch-stage PC mux select.
package intc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    PUSH_PC  = 3'd2,
    PUSH_CCR = 3'd3,
    REDIRECT = 3'd4,
    SERVICE  = 3'd5
  } intc_state_t;

  localparam logic [31:0] INTC_DEFAULT_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/intc_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for the external interrupt line.
// Compiled only when INTC_SYNC_EN is defined.
`ifdef INTC_SYNC_EN
module intc_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= level;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  // A held level yields exactly one request.
  assign rise = sync & ~sync_q;

endmodule
`endif

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: drain, push return PC and CCR, redirect to vector, mask until RTI.
// Define INTC_SYNC_EN when int_in is asynchronous to clk (adds synchronizer and edge detect).
module interrupt_sequencer
  import intc_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] VECTOR_ADDR  = PC_W'(INTC_DEFAULT_VECTOR),
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_in,
  input  logic [PC_W-1:0] ret_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            push_ack,
  input  logic            rti_done,
  output logic            freeze_fetch,
  output logic            push_pc,
  output logic            push_ccr,
  output logic [PC_W-1:0] save_pc,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_vector,
  output logic            in_service
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("interrupt_sequencer: DRAIN_CYCLES must be at least 1");
  end

  logic req;

`ifdef INTC_SYNC_EN
  intc_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .level (int_in),
    .rise  (req)
  );
`else
  assign req = int_in;
`endif

  intc_state_t     state;
  intc_state_t     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic            pending;
  logic            pending_next;
  logic [PC_W-1:0] save_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      save_pc <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      pending <= pending_next;
      save_pc <= save_next;
    end
  end

  // Requests arriving while busy coalesce into the one-deep pending flag.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pending_next = pending | req;
    save_next    = save_pc;
    freeze_fetch = 1'b0;
    push_pc      = 1'b0;
    push_ccr     = 1'b0;
    pc_load      = 1'b0;
    in_service   = 1'b0;
    case (state)
      IDLE: begin
        if (req || pending) begin
          state_next   = DRAIN;
          save_next    = ret_pc;
          cnt_next     = CNT_RELOAD;
          pending_next = 1'b0;
        end
      end
      DRAIN: begin
        freeze_fetch = 1'b1;
        // A taken branch makes the captured return address wrong-path; restart the drain.
        if (br_taken) begin
          save_next = br_target;
          cnt_next  = CNT_RELOAD;
        end else if (cnt == '0) begin
          state_next = PUSH_PC;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      PUSH_PC: begin
        freeze_fetch = 1'b1;
        push_pc      = 1'b1;
        if (push_ack) state_next = PUSH_CCR;
      end
      PUSH_CCR: begin
        freeze_fetch = 1'b1;
        push_ccr     = 1'b1;
        if (push_ack) state_next = REDIRECT;
      end
      REDIRECT: begin
        pc_load    = 1'b1;
        state_next = SERVICE;
      end
      SERVICE: begin
        in_service = 1'b1;
        if (rti_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_vector = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized scoreboard bench for interrupt_sequencer: episodes are planned from the
// sequencing rules, expected phase lengths are queued, and a monitor measures what the DUT does.
module tb_interrupt_sequencer;

  localparam int          PC_W = 32;
  localparam int          D    = 4;
  localparam logic [31:0] VEC  = 32'h0000_0100;
  localparam int          N_EP = 40;

  logic            clk       = 1'b0;
  logic            reset     = 1'b0;
  logic            int_in    = 1'b0;
  logic [PC_W-1:0] ret_pc    = '0;
  logic            br_taken  = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic            push_ack  = 1'b0;
  logic            rti_done  = 1'b0;
  logic            freeze_fetch;
  logic            push_pc;
  logic            push_ccr;
  logic [PC_W-1:0] save_pc;
  logic            pc_load;
  logic [PC_W-1:0] pc_vector;
  logic            in_service;

  always #5 clk = ~clk;

  interrupt_sequencer #(
    .PC_W         (PC_W),
    .VECTOR_ADDR  (VEC),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .int_in       (int_in),
    .ret_pc       (ret_pc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .push_ack     (push_ack),
    .rti_done     (rti_done),
    .freeze_fetch (freeze_fetch),
    .push_pc      (push_pc),
    .push_ccr     (push_ccr),
    .save_pc      (save_pc),
    .pc_load      (pc_load),
    .pc_vector    (pc_vector),
    .in_service   (in_service)
  );

  typedef struct {
    logic        rst;
    logic        irq;
    logic [31:0] pc;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic        rti;
    int          ep;
  } stim_t;

  typedef struct {
    int          gap;
    int          drain;
    int          ppc;
    int          pccr;
    int          redir;
    logic [31:0] save;
    int          serv;
  } episode_t;

  stim_t    sched[$];
  episode_t eps[$];
  episode_t exp_q[$];
  episode_t meas;
  episode_t exp_e;
  int       n_cmp   = 0;
  int       n_fail  = 0;
  int       ep_seen = 0;
  int       pre_idle = 0;
  int       cur = 0;
  int       run = 0;
  int       ph;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (episode %0d): got %0h, expected %0h", name, ep_seen, act, exp);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.rst = 1'b1;
    s.irq = 1'b0;
    s.pc  = $urandom & 32'hFFFF_FFFC;
    s.br  = 1'b0;
    s.tgt = $urandom & 32'hFFFF_FFFC;
    s.ack = 1'b0;
    s.rti = 1'b0;
    s.ep  = -1;
    return s;
  endfunction

  task automatic buildReset(input int n);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = quiet();
      s.rst = 1'b0;
      sched.push_back(s);
    end
    sched.push_back(quiet());
    pre_idle = 1;
  endtask

  // One full entry/service/exit episode; the expected phase lengths follow from the plan.
  task automatic buildEpisode(input bit pend_in, input bit allow_pend, input bit directed,
                              output bit pend_out);
    stim_t s;
    episode_t e;
    int g, mode, i, j, len, a1, a2, sv, npulse, p1;
    logic [31:0] t1, t2;
    if (pend_in)           g = 0;
    else if (pre_idle > 0) g = 3 + int'($urandom_range(0, 2));
    else                   g = int'($urandom_range(0, 4));
    for (int k = 0; k < g; k++) sched.push_back(quiet());
    pre_idle += g;
    s = quiet();
    s.irq = !pend_in;
    if (directed) s.pc = 32'h20;
    s.ep = eps.size();
    e.save = s.pc;
    sched.push_back(s);
    pre_idle++;
    e.gap = pre_idle;

    mode = directed ? 0 : int'($urandom_range(0, 2));
    i    = int'($urandom_range(0, D - 1));
    j    = i + 1 + int'($urandom_range(0, D - 1));
    t1   = $urandom & 32'hFFFF_FFFC;
    t2   = $urandom & 32'hFFFF_FFFC;
    len  = (mode == 0) ? D : (mode == 1) ? i + 1 + D : j + 1 + D;
    for (int k = 0; k < len; k++) begin
      s = quiet();
      s.ack = 1'($urandom);
      s.rti = 1'($urandom);
      if (mode >= 1 && k == i) begin s.br = 1'b1; s.tgt = t1; e.save = t1; end
      if (mode == 2 && k == j) begin s.br = 1'b1; s.tgt = t2; e.save = t2; end
      sched.push_back(s);
    end
    e.drain = len;

    a1 = directed ? 0 : int'($urandom_range(0, 3));
    a2 = directed ? 0 : int'($urandom_range(0, 3));
    for (int k = 0; k <= a1; k++) begin
      s = quiet();
      s.ack = (k == a1);
      s.br  = 1'($urandom);
      s.rti = 1'($urandom);
      sched.push_back(s);
    end
    for (int k = 0; k <= a2; k++) begin
      s = quiet();
      s.ack = (k == a2);
      s.br  = 1'($urandom);
      s.rti = 1'($urandom);
      sched.push_back(s);
    end
    e.ppc  = a1 + 1;
    e.pccr = a2 + 1;

    s = quiet();
    s.ack = 1'($urandom);
    s.br  = 1'($urandom);
    sched.push_back(s);
    e.redir = 1;

    sv     = int'($urandom_range(0, 6));
    npulse = allow_pend ? int'($urandom_range(0, 2)) : 0;
    p1     = int'($urandom_range(0, sv));
    for (int k = 0; k <= sv; k++) begin
      s = quiet();
      s.rti = (k == sv);
      s.br  = 1'($urandom);
      s.ack = 1'($urandom);
      if (npulse >= 1 && k == p1)     s.irq = 1'b1;
      if (npulse == 2 && k == p1 + 2) s.irq = 1'b1;
      sched.push_back(s);
    end
    e.serv   = sv + 1;
    pend_out = (npulse >= 1);
    eps.push_back(e);
    pre_idle = 0;
  endtask

  // Entry interrupted by reset while pushing the CCR, with a request pending.
  task automatic buildAbort();
    stim_t s;
    for (int k = 0; k < 3; k++) sched.push_back(quiet());
    s = quiet();
    s.irq = 1'b1;
    sched.push_back(s);
    for (int k = 0; k < D; k++) begin
      s = quiet();
      s.irq = (k == D - 1);
      sched.push_back(s);
    end
    s = quiet();
    s.ack = 1'b1;
    sched.push_back(s);
    sched.push_back(quiet());
    buildReset(1);
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < sched.size(); k++) begin
      @(posedge clk);
      #1;
      reset     = sched[k].rst;
      ret_pc    = sched[k].pc;
      br_taken  = sched[k].br;
      br_target = sched[k].tgt;
      push_ack  = sched[k].ack;
      rti_done  = sched[k].rti;
`ifdef INTC_SYNC_EN
      int_in    = (k + 2 < sched.size()) ? sched[k + 2].irq : 1'b0;
`else
      int_in    = sched[k].irq;
`endif
      if (sched[k].ep >= 0) exp_q.push_back(eps[sched[k].ep]);
    end
  endtask

  task automatic clearMeas();
    meas.gap = -1; meas.drain = -1; meas.ppc = -1; meas.pccr = -1;
    meas.redir = -1; meas.serv = -1; meas.save = '0;
  endtask

  task automatic finishEpisode();
    ep_seen++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL episode_count: episode %0d observed with none expected", ep_seen);
    end else begin
      exp_e = exp_q.pop_front();
      checkOutput("idle_gap",      64'(meas.gap),   64'(exp_e.gap));
      checkOutput("drain_cycles",  64'(meas.drain), 64'(exp_e.drain));
      checkOutput("push_pc_cycles", 64'(meas.ppc),  64'(exp_e.ppc));
      checkOutput("push_ccr_cycles", 64'(meas.pccr), 64'(exp_e.pccr));
      checkOutput("pc_load_cycles", 64'(meas.redir), 64'(exp_e.redir));
      checkOutput("save_pc",       64'(meas.save),  64'(exp_e.save));
      checkOutput("service_cycles", 64'(meas.serv), 64'(exp_e.serv));
    end
    clearMeas();
  endtask

  initial clearMeas();

  // Monitor: run-length measures each phase and scores an episode when service ends.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("reset_freeze_fetch", 64'(freeze_fetch), 64'd0);
      checkOutput("reset_push_pc",      64'(push_pc),      64'd0);
      checkOutput("reset_push_ccr",     64'(push_ccr),     64'd0);
      checkOutput("reset_pc_load",      64'(pc_load),      64'd0);
      checkOutput("reset_in_service",   64'(in_service),   64'd0);
      checkOutput("reset_save_pc",      64'(save_pc),      64'd0);
      cur = 0;
      run = 0;
      clearMeas();
    end else begin
      case ({freeze_fetch, push_pc, push_ccr, pc_load, in_service})
        5'b00000: ph = 0;
        5'b10000: ph = 1;
        5'b11000: ph = 2;
        5'b10100: ph = 3;
        5'b00010: ph = 4;
        5'b00001: ph = 5;
        default:  ph = 7;
      endcase
      checkOutput("legal_output_set", 64'(ph == 7), 64'd0);
      if (ph == cur) begin
        run++;
      end else begin
        case (cur)
          0: meas.gap   = run;
          1: meas.drain = run;
          2: meas.ppc   = run;
          3: meas.pccr  = run;
          4: meas.redir = run;
          5: meas.serv  = run;
          default: ;
        endcase
        if (cur == 5) finishEpisode();
        cur = ph;
        run = 1;
      end
      if (ph == 4) checkOutput("pc_vector", 64'(pc_vector), 64'(VEC));
      if (ph == 3) meas.save = save_pc;
    end
  end

  initial begin
    bit pend;
    pend = 1'b0;
    buildReset(3);
    for (int ep = 0; ep < N_EP; ep++) begin
      if (ep == N_EP / 2) buildAbort();
      buildEpisode(pend, !(ep == N_EP / 2 - 1 || ep == N_EP - 1), ep == 0, pend);
    end
    for (int k = 0; k < 10; k++) sched.push_back(quiet());
    $display("[TB] playing %0d cycles, %0d episodes", sched.size(), eps.size());
    applyStimulus();
    @(posedge clk);
    #1;
    checkOutput("leftover_expected", 64'(exp_q.size()), 64'd0);
    checkOutput("episodes_seen",     64'(ep_seen),      64'(eps.size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
